// File: rtl/led7_pkg.sv
// Shared definitions for the multiplexed seven-segment scanner: segment
// patterns (active-low {g,f,e,d,c,b,a}), the blank pattern and an index-width helper.
package led7_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_0     = 7'b1000000;
  localparam seg_t SEG_1     = 7'b1111001;
  localparam seg_t SEG_2     = 7'b0100100;
  localparam seg_t SEG_3     = 7'b0110000;
  localparam seg_t SEG_4     = 7'b0011001;
  localparam seg_t SEG_5     = 7'b0010010;
  localparam seg_t SEG_6     = 7'b0000010;
  localparam seg_t SEG_7     = 7'b1111000;
  localparam seg_t SEG_8     = 7'b0000000;
  localparam seg_t SEG_9     = 7'b0010000;
  localparam seg_t SEG_A     = 7'b0001000;
  localparam seg_t SEG_B     = 7'b0000011;
  localparam seg_t SEG_C     = 7'b1000110;
  localparam seg_t SEG_D     = 7'b0100001;
  localparam seg_t SEG_E     = 7'b0000110;
  localparam seg_t SEG_F     = 7'b0001110;
  localparam seg_t SEG_BLANK = 7'h7F;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int idx_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/led7_hex_dec.sv
// Combinational hex nibble to active-low seven-segment decoder.
module led7_hex_dec
  import led7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Standard hex glyphs, lower-case b and d to stay distinct from 8 and 0.
  always_comb begin
    seg = SEG_BLANK;
    case (nibble)
      4'h0:    seg = SEG_0;
      4'h1:    seg = SEG_1;
      4'h2:    seg = SEG_2;
      4'h3:    seg = SEG_3;
      4'h4:    seg = SEG_4;
      4'h5:    seg = SEG_5;
      4'h6:    seg = SEG_6;
      4'h7:    seg = SEG_7;
      4'h8:    seg = SEG_8;
      4'h9:    seg = SEG_9;
      4'hA:    seg = SEG_A;
      4'hB:    seg = SEG_B;
      4'hC:    seg = SEG_C;
      4'hD:    seg = SEG_D;
      4'hE:    seg = SEG_E;
      4'hF:    seg = SEG_F;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/led7_scan.sv
// Time-multiplexed seven-segment driver with tear-free double-buffered load.
// Optional leading-zero blanking is enabled by defining LED7_SCAN_LZB_EN.
module led7_scan
  import led7_pkg::*;
#(
  parameter int P_DIGITS   = 4,
  parameter int P_PRESCALE = 50000
) (
  input  logic                  i_w_clk,
  input  logic                  i_w_reset,
  input  logic                  i_w_en,
  input  logic                  i_w_load,
  input  logic [4*P_DIGITS-1:0] i_w_data,
  output logic [6:0]            o_w_seg,
  output logic [P_DIGITS-1:0]   o_w_an,
  output logic                  o_w_busy,
  output logic                  o_w_frame
);

  localparam int CNT_W = idx_width(P_PRESCALE);
  localparam int IDX_W = idx_width(P_DIGITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(P_PRESCALE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(P_DIGITS - 1);

  logic [CNT_W-1:0]      cnt_r;
  logic [IDX_W-1:0]      idx_r;
  logic [4*P_DIGITS-1:0] pending_r;
  logic [4*P_DIGITS-1:0] committed_r;
  logic                  busy_r;
  logic                  frame_r;
  logic [6:0]            seg_r;
  logic [P_DIGITS-1:0]   an_r;

  logic                  cnt_wrap_s;
  logic                  frame_s;
  logic [3:0]            digit_s;
  logic [6:0]            dec_seg_s;
  logic                  blank_s;
  logic [6:0]            seg_nxt_s;
  logic [P_DIGITS-1:0]   an_nxt_s;

  assign cnt_wrap_s = (cnt_r == CNT_LAST);
  assign frame_s    = cnt_wrap_s && (idx_r == IDX_LAST);

  // Prescaler and digit index; a digit is driven for P_PRESCALE cycles.
  always_ff @(posedge i_w_clk) begin
    if (i_w_reset) begin
      cnt_r <= '0;
      idx_r <= '0;
    end else if (cnt_wrap_s) begin
      cnt_r <= '0;
      idx_r <= (idx_r == IDX_LAST) ? '0 : idx_r + IDX_W'(1);
    end else begin
      cnt_r <= cnt_r + CNT_W'(1);
      idx_r <= idx_r;
    end
  end

  // Double buffer: the committed value only changes at a frame boundary,
  // and a load landing on the boundary itself bypasses the pending stage.
  always_ff @(posedge i_w_clk) begin
    if (i_w_reset) begin
      pending_r   <= '0;
      committed_r <= '0;
      busy_r      <= 1'b0;
    end else if (i_w_load && frame_s) begin
      pending_r   <= i_w_data;
      committed_r <= i_w_data;
      busy_r      <= 1'b0;
    end else if (i_w_load) begin
      pending_r   <= i_w_data;
      committed_r <= committed_r;
      busy_r      <= 1'b1;
    end else if (frame_s && busy_r) begin
      pending_r   <= pending_r;
      committed_r <= pending_r;
      busy_r      <= 1'b0;
    end else begin
      pending_r   <= pending_r;
      committed_r <= committed_r;
      busy_r      <= busy_r;
    end
  end

  // Nibble of the committed value for the digit currently scanned.
  always_comb begin
    digit_s = 4'h0;
    for (int k = 0; k < P_DIGITS; k++) begin
      digit_s = (idx_r == IDX_W'(k)) ? committed_r[4*k +: 4] : digit_s;
    end
  end

  led7_hex_dec u_hex_dec (
    .nibble (digit_s),
    .seg    (dec_seg_s)
  );

`ifdef LED7_SCAN_LZB_EN
  logic [IDX_W-1:0] msd_s;

  // Highest non-zero digit; digit 0 stays lit even for an all-zero value.
  always_comb begin
    msd_s = '0;
    for (int k = 1; k < P_DIGITS; k++) begin
      msd_s = (committed_r[4*k +: 4] != 4'h0) ? IDX_W'(k) : msd_s;
    end
  end

  assign blank_s = (idx_r > msd_s);
`else
  assign blank_s = 1'b0;
`endif

  assign seg_nxt_s = blank_s ? SEG_BLANK : dec_seg_s;

  // Anode select: one digit low while enabled, all dark otherwise.
  always_comb begin
    an_nxt_s = {P_DIGITS{1'b1}};
    if (i_w_en) begin
      an_nxt_s[idx_r] = 1'b0;
    end else begin
      an_nxt_s = {P_DIGITS{1'b1}};
    end
  end

  // Registered pin drivers, one cycle behind the scan state.
  always_ff @(posedge i_w_clk) begin
    if (i_w_reset) begin
      seg_r   <= SEG_BLANK;
      an_r    <= {P_DIGITS{1'b1}};
      frame_r <= 1'b0;
    end else begin
      seg_r   <= seg_nxt_s;
      an_r    <= an_nxt_s;
      frame_r <= frame_s;
    end
  end

  assign o_w_seg   = seg_r;
  assign o_w_an    = an_r;
  assign o_w_busy  = busy_r;
  assign o_w_frame = frame_r;

endmodule

// File: tb/tb_led7_scan.sv
// Directed bench for led7_scan with P_DIGITS=4, P_PRESCALE=4 (16-cycle frame).
module tb_led7_scan;

  logic        clk;
  logic        reset;
  logic        en;
  logic        load;
  logic [15:0] data;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        busy;
  logic        frame;

  int checks   = 0;
  int failures = 0;
  int e        = 0;   // rising edges since reset was released

  logic [3:0] an_tab [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

`ifdef LED7_SCAN_LZB_EN
  localparam logic [6:0] SEG_LEAD0 = 7'b1111111;
`else
  localparam logic [6:0] SEG_LEAD0 = 7'b1000000;
`endif

  led7_scan #(.P_DIGITS(4), .P_PRESCALE(4)) dut (
    .i_w_clk   (clk),
    .i_w_reset (reset),
    .i_w_en    (en),
    .i_w_load  (load),
    .i_w_data  (data),
    .o_w_seg   (seg),
    .o_w_an    (an),
    .o_w_busy  (busy),
    .o_w_frame (frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    e++;
  endtask

  task automatic run_to(input int target);
    while (e < target) step();
  endtask

  initial begin
    reset = 1'b1;
    en    = 1'b1;
    load  = 1'b0;
    data  = 16'h0000;

    // Reset held for two edges
    step();
    step();
    chk("rst_an", 32'(an), 32'h0000000F);
    chk("rst_seg", 32'(seg), 32'h0000007F);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_frame", 32'(frame), 32'h0);
    reset = 1'b0;
    e = 0;

    // Free-running scan over two frames
    for (int i = 0; i < 32; i++) begin
      step();
      chk("scan_an", 32'(an), 32'(an_tab[((e - 1) / 4) % 4]));
      chk("scan_frame", 32'(frame), (e % 16 == 0) ? 32'h1 : 32'h0);
      if (e == 1) chk("scan_seg0", 32'(seg), 32'h40);
    end

    // Mid-frame load waits for the next boundary
    run_to(36);
    load = 1'b1;
    data = 16'h12AF;
    step();
    load = 1'b0;
    chk("commit_busy_set", 32'(busy), 32'h1);
    run_to(47);
    chk("commit_busy_hold", 32'(busy), 32'h1);
    run_to(48);
    chk("commit_busy_clr", 32'(busy), 32'h0);
    chk("commit_frame", 32'(frame), 32'h1);
    chk("commit_no_tear", 32'(seg), 32'(SEG_LEAD0));
    run_to(49);
    chk("commit_d0", 32'(seg), 32'h0E);
    chk("commit_an0", 32'(an), 32'hE);

    // Two loads in one frame; the second one wins
    load = 1'b1;
    data = 16'h1111;
    step();
    load = 1'b0;
    run_to(53);
    chk("commit_d1", 32'(seg), 32'h08);
    run_to(54);
    load = 1'b1;
    data = 16'h8888;
    step();
    load = 1'b0;
    run_to(57);
    chk("commit_d2", 32'(seg), 32'h24);
    run_to(61);
    chk("commit_d3", 32'(seg), 32'h79);
    run_to(63);
    chk("ovw_busy", 32'(busy), 32'h1);
    run_to(64);
    chk("ovw_busy_clr", 32'(busy), 32'h0);
    chk("ovw_old_d3", 32'(seg), 32'h79);
    for (int d = 0; d < 4; d++) begin
      run_to(65 + 4 * d);
      chk("ovw_seg", 32'(seg), 32'h00);
      chk("ovw_an", 32'(an), 32'(an_tab[d]));
    end

    // Load exactly on a boundary commits directly
    run_to(79);
    load = 1'b1;
    data = 16'h0030;
    step();
    load = 1'b0;
    chk("bnd_busy", 32'(busy), 32'h0);
    run_to(81);
    chk("lzb_d0", 32'(seg), 32'h40);
    run_to(85);
    chk("lzb_d1", 32'(seg), 32'h30);
    run_to(89);
    chk("lzb_d2", 32'(seg), 32'(SEG_LEAD0));
    run_to(93);
    chk("lzb_d3", 32'(seg), 32'(SEG_LEAD0));

    // Display disabled: anodes dark, frame timing unchanged
    run_to(96);
    en = 1'b0;
    for (int i = 0; i < 16; i++) begin
      step();
      chk("dis_an", 32'(an), 32'hF);
      chk("dis_frame", 32'(frame), (e % 16 == 0) ? 32'h1 : 32'h0);
    end
    en = 1'b1;
    run_to(114);
    chk("reen_an", 32'(an), 32'hE);

    // Reset mid-frame drops pending data and a coincident load
    run_to(115);
    load = 1'b1;
    data = 16'h8888;
    step();
    load = 1'b0;
    chk("pre_rst_busy", 32'(busy), 32'h1);
    run_to(118);
    reset = 1'b1;
    load  = 1'b1;
    data  = 16'hFFFF;
    step();
    chk("mid_rst_an", 32'(an), 32'hF);
    chk("mid_rst_seg", 32'(seg), 32'h7F);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    chk("mid_rst_frame", 32'(frame), 32'h0);
    reset = 1'b0;
    load  = 1'b0;
    e = 0;
    run_to(1);
    chk("post_rst_an", 32'(an), 32'hE);
    chk("post_rst_seg", 32'(seg), 32'h40);
    chk("post_rst_busy", 32'(busy), 32'h0);
    run_to(15);
    chk("post_rst_noframe", 32'(frame), 32'h0);
    run_to(16);
    chk("post_rst_frame", 32'(frame), 32'h1);
    run_to(17);
    chk("post_rst_d0", 32'(seg), 32'h40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
